// File: rtl/itf_pkg.sv
// Shared widths, FSM encoding and requester IDs for the int_to_float arbiter.
package itf_pkg;

  localparam int DEF_DW = 12;
  localparam int DEF_EW = 3;
  localparam int DEF_FW = 4;
  localparam int DEF_CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/itf_arbiter_int_to_float.sv
// Combinational two's complement integer to tiny float (value = F * 2^E),
// round on the first dropped bit, saturate to all-ones E/F on overflow.
module int_to_float
  import itf_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int EW = DEF_EW,
  parameter int FW = DEF_FW
) (
  input  logic [DW-1:0] d,
  output logic          s,
  output logic [EW-1:0] e,
  output logic [FW-1:0] f
);

  logic [DW-1:0] mag;
  logic [4:0]    lead;
  logic [4:0]    shamt;
  logic [4:0]    e_full;
  logic [FW-1:0] trunc;
  logic          rnd;
  logic [FW:0]   sum;
  logic [FW-1:0] f_rnd;

  always_comb begin
    s     = d[DW-1];
    mag   = s ? (~d) + {{(DW-1){1'b0}}, 1'b1} : d;
    lead  = 5'd0;
    for (int i = 0; i < DW; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    shamt = (lead > 5'(FW-1)) ? lead - 5'(FW-1) : 5'd0;
    trunc = FW'(mag >> shamt);
    rnd   = (shamt != 5'd0) ? mag[shamt - 5'd1] : 1'b0;
    sum   = {1'b0, trunc} + {{FW{1'b0}}, rnd};
    // A rounding carry out of the significand renormalises to 1000 and bumps E.
    if (sum[FW]) begin
      e_full = shamt + 5'd1;
      f_rnd  = {1'b1, {(FW-1){1'b0}}};
    end else begin
      e_full = shamt;
      f_rnd  = sum[FW-1:0];
    end
    if (e_full > 5'((1 << EW) - 1)) begin
      e = '1;
      f = '1;
    end else begin
      e = e_full[EW-1:0];
      f = f_rnd;
    end
  end

endmodule

// File: rtl/itf_arbiter.sv
// Round-robin arbiter sharing one int_to_float between two req/gnt/done
// requesters. Operand and result are registered; one conversion per 3 cycles.
module itf_arbiter
  import itf_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int EW = DEF_EW,
  parameter int FW = DEF_FW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [DW-1:0] d0,
  input  logic          req1,
  input  logic [DW-1:0] d1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          s_out,
  output logic [EW-1:0] e_out,
  output logic [FW-1:0] f_out,
  output logic          busy,
  output logic [CW-1:0] conv_count
);

  state_t        state;
  logic [DW-1:0] op_reg;
  logic          owner;
  logic          rr_ptr;
  logic          winner;
  logic          conv_s;
  logic [EW-1:0] conv_e;
  logic [FW-1:0] conv_f;

  int_to_float #(.DW(DW), .EW(EW), .FW(FW)) u_conv (
    .d (op_reg),
    .s (conv_s),
    .e (conv_e),
    .f (conv_f)
  );

  // rr_ptr only breaks ties; a lone requester always wins.
  always_comb begin
    if (req0 && req1) winner = rr_ptr;
    else if (req1)    winner = REQ1;
    else              winner = REQ0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_reg     <= '0;
      owner      <= REQ0;
      rr_ptr     <= REQ0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      s_out      <= 1'b0;
      e_out      <= '0;
      f_out      <= '0;
      busy       <= 1'b0;
      conv_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            op_reg <= (winner == REQ1) ? d1 : d0;
            owner  <= winner;
            gnt0   <= (winner == REQ0);
            gnt1   <= (winner == REQ1);
            rr_ptr <= ~winner;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          gnt0       <= 1'b0;
          gnt1       <= 1'b0;
          s_out      <= conv_s;
          e_out      <= conv_e;
          f_out      <= conv_f;
          done0      <= (owner == REQ0);
          done1      <= (owner == REQ1);
          conv_count <= conv_count + 1'b1;
          state      <= DONE;
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itf_arbiter.sv
// Directed bench for itf_arbiter: reset, single/contended requests,
// rounding/saturation vectors, mid-operation reset and counter wrap.
module tb_itf_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0;
  logic [11:0] d0;
  logic        req1;
  logic [11:0] d1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic        s_out;
  logic [2:0]  e_out;
  logic [3:0]  f_out;
  logic        busy;
  logic [7:0]  conv_count;

  int checks;
  int errors;

  logic [20:0] all_outs;
  assign all_outs = {gnt0, gnt1, done0, done1, s_out, e_out, f_out, busy, conv_count};

  itf_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .d0         (d0),
    .req1       (req1),
    .d1         (d1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .s_out      (s_out),
    .e_out      (e_out),
    .f_out      (f_out),
    .busy       (busy),
    .conv_count (conv_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Expects a conversion granted at the next edge: gnt, then done with SEF, then idle.
  task automatic expect_conv(input string tag, input logic who,
                             input logic es, input logic [2:0] ee, input logic [3:0] ef,
                             input logic drop_in_done);
    step();
    check({tag, " gnt"}, {30'd0, gnt1, gnt0}, who ? 32'd2 : 32'd1);
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    step();
    check({tag, " done"}, {30'd0, done1, done0}, who ? 32'd2 : 32'd1);
    check({tag, " sef"}, {24'd0, s_out, e_out, f_out}, {24'd0, es, ee, ef});
    if (drop_in_done) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    step();
    check({tag, " idle"}, {28'd0, busy, done1, done0, gnt0 | gnt1}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req0   = 1'b0;
    req1   = 1'b0;
    d0     = '0;
    d1     = '0;

    // reset then idle
    step();
    check("reset outs", {11'd0, all_outs}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle outs", {11'd0, all_outs}, 32'd0);
    end

    // single request, req dropped right after grant
    req0 = 1'b1;
    d0   = 12'd100;
    step();
    check("single gnt0", {31'd0, gnt0}, 32'd1);
    check("single done0 early", {31'd0, done0}, 32'd0);
    req0 = 1'b0;
    step();
    check("single done0", {31'd0, done0}, 32'd1);
    check("single sef", {24'd0, s_out, e_out, f_out}, {24'd0, 1'b0, 3'd3, 4'd13});
    check("single count", {24'd0, conv_count}, 32'd1);
    step();
    check("single busy off", {31'd0, busy}, 32'd0);
    check("single hold sef", {24'd0, s_out, e_out, f_out}, {24'd0, 1'b0, 3'd3, 4'd13});

    // negative operand with round-up
    req0 = 1'b1;
    d0   = -12'sd100;
    expect_conv("neg100", 1'b0, 1'b1, 3'd3, 4'd13, 1'b1);

    // contention from a fresh pointer: grants alternate 0,1,0
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    d0   = 12'h800;
    d1   = 12'd5;
    expect_conv("rr first", 1'b0, 1'b1, 3'd7, 4'd15, 1'b0);
    expect_conv("rr second", 1'b1, 1'b0, 3'd0, 4'd5, 1'b0);
    expect_conv("rr third", 1'b0, 1'b1, 3'd7, 4'd15, 1'b1);
    step();
    check("rr no repeat", {30'd0, busy, gnt0 | gnt1}, 32'd0);
    check("rr count", {24'd0, conv_count}, 32'd3);

    // saturation via rounding carry, then zero; result holds meanwhile
    req1 = 1'b1;
    d1   = 12'd2047;
    expect_conv("sat2047", 1'b1, 1'b0, 3'd7, 4'd15, 1'b1);
    req1 = 1'b1;
    d1   = 12'd0;
    step();
    check("sat hold", {24'd0, s_out, e_out, f_out}, {24'd0, 1'b0, 3'd7, 4'd15});
    req1 = 1'b0;
    step();
    check("zero done1", {31'd0, done1}, 32'd1);
    check("zero sef", {24'd0, s_out, e_out, f_out}, 32'd0);
    step();

    // reset while in CONV discards the conversion
    req1 = 1'b1;
    d1   = 12'd5;
    step();
    check("midrst gnt1", {31'd0, gnt1}, 32'd1);
    req1  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst outs", {11'd0, all_outs}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst no done", {29'd0, busy, done1, done0}, 32'd0);
    check("midrst count", {24'd0, conv_count}, 32'd0);
    req1 = 1'b1;
    d1   = 12'd100;
    expect_conv("after rst", 1'b1, 1'b0, 3'd3, 4'd13, 1'b1);
    check("after rst count", {24'd0, conv_count}, 32'd1);

    // 256 back-to-back conversions wrap the counter
    do_reset();
    req0 = 1'b1;
    d0   = 12'd7;
    for (int i = 0; i < 256; i++) begin
      step();
      step();
      if (i == 254) check("wrap 255", {24'd0, conv_count}, 32'd255);
      if (i == 255) begin
        check("wrap 0", {24'd0, conv_count}, 32'd0);
        check("wrap done0", {31'd0, done0}, 32'd1);
        req0 = 1'b0;
      end
      step();
    end
    check("wrap sef", {24'd0, s_out, e_out, f_out}, {24'd0, 1'b0, 3'd0, 4'd7});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/itf_arbiter.md
Name: itf_arbiter

Overview:
- Shares one combinational int_to_float converter (12-bit two's complement in; S, 3-bit E, 4-bit F out) between two requesters.
- Round-robin arbitration; each requester uses a req/gnt/done handshake.
- Operand and result are both registered.
- Also keeps a wrapping count of completed conversions for debug readback.

Parameters:
- DW, 12, operand width (two's complement integer)
- EW, 3, exponent width
- FW, 4, significand width
- CW, 8, conversion counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 wants a conversion; hold high with d0 stable until gnt0
- d0  in  DW  requester 0 operand
- req1  in  1  requester 1 wants a conversion
- d1  in  DW  requester 1 operand
- gnt0  out  1  one-cycle pulse: d0 captured
- gnt1  out  1  one-cycle pulse: d1 captured
- done0  out  1  one-cycle pulse: result for requester 0 valid on s_out/e_out/f_out
- done1  out  1  one-cycle pulse: result for requester 1 valid
- s_out  out  1  sign of last result
- e_out  out  EW  exponent of last result
- f_out  out  FW  significand of last result
- busy  out  1  high whenever state is not IDLE
- conv_count  out  CW  completed conversions, modulo 2^CW

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces:
  - state=IDLE; all outputs 0
  - op_reg=0, owner=0, rr_ptr=0 (requester 0 preferred first)
- FSM states: IDLE, CONV, DONE; all outputs registered.
- IDLE, at an edge with req0|req1:
  - select the winner; op_reg<=d_winner; owner<=winner; gnt_winner<=1; state<=CONV
  - rr_ptr<=~winner
- Winner selection: only one req high → that one; both high → the requester indexed by rr_ptr.
- CONV, next edge: gnt<=0; {s_out,e_out,f_out}<=int_to_float(op_reg); done_owner<=1; conv_count<=conv_count+1; state<=DONE.
- DONE, next edge: done<=0; state<=IDLE.
- Latency: req sampled at edge k → gnt high cycle k..k+1, done high cycle k+1..k+2, IDLE again after edge k+2.
- Throughput: one conversion per 3 cycles.
- Results hold on s_out/e_out/f_out until overwritten by the next CONV edge.
- Requests are not sampled in CONV or DONE.
- A req still high in the first IDLE cycle after done counts as a new request. Requesters must drop req in the done cycle to avoid a repeat.
- req dropped before it is sampled: no effect.
- req dropped after gnt: conversion still completes and done still pulses.
- conv_count wraps from 2^CW-1 to 0 with no flag.
- Reset mid-operation: in-flight conversion is discarded, no done pulse, outputs cleared immediately.
- Conversion arithmetic belongs entirely to int_to_float: sign-magnitude, exponent from leading-zero count, 5th-bit rounding, saturation to E=7, F=15. The arbiter does not alter it.

Decomposition:
- Package itf_pkg: DW/EW/FW/CW defaults, state encoding (IDLE=2'd0, CONV=2'd1, DONE=2'd2), requester IDs (REQ0=1'b0, REQ1=1'b1).
- Sub-module: one instance of the existing int_to_float, fed from op_reg. No other sub-modules.

Test Plan:
- Reset then idle: rst_n low mid-run → all outputs 0, busy=0. Release with no req → outputs stay 0 for 10 cycles.
- Single request: req0=1, d0=100 at edge k → gnt0 in cycle k+1. done0 in cycle k+2 with s=0, e=3, f=13. conv_count=1. busy back to 0 after edge k+2.
- Simultaneous requests: req0=req1=1, d0=-2048, d1=5, both held →
  - first done0 with s=1, e=7, f=15
  - then done1 with s=0, e=0, f=5
  - then done0 again; grants alternate 0,1,0
- Saturation and zero: d1=2047 → s=0, e=7, f=15. Then d1=0 → s=0, e=0, f=0. Each result holds until the next done.
- Reset mid-operation: assert rst_n=0 during CONV → no done pulse, conv_count=0, state IDLE. Next req1 completes normally.
- Counter wrap: run 256 back-to-back single-requester conversions → conv_count reads 0 after the 256th done.
